// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD <-> binary conversion blocks.
package bcd_pkg;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  localparam int DIGIT_W = 4;

  // A packed-BCD digit is only meaningful in the range 0..9.
  function automatic logic digit_invalid(logic [3:0] d);
    return (d > 4'd9);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: after a right shift,
// a digit of 8 or more absorbed a carry-in worth 8 but should be worth 5.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule : bcd_digit_adjust

// File: rtl/bcd_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble),
// one shift/adjust step per clock, 4*DIGITS steps per conversion.
module bcd_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [DIGIT_W*DIGITS-1:0]    bcd,
  output logic                         busy,
  output logic                         done,
  output logic [BIN_WIDTH-1:0]         binary,
  output logic                         error
);

  localparam int SR_W  = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(SR_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SR_W - 1);

  state_t                 state_reg, state_next;
  logic [SR_W-1:0]        bcd_reg, bcd_next;
  logic [SR_W-1:0]        bin_reg, bin_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   err_reg, err_next;
  logic                   done_reg, done_next;
  logic [BIN_WIDTH-1:0]   binary_reg, binary_next;
  logic                   error_reg, error_next;

  logic [2*SR_W-1:0]      shifted;
  logic [SR_W-1:0]        bcd_shift;
  logic [SR_W-1:0]        bin_shift;
  logic [SR_W-1:0]        bcd_adj;
  logic [DIGITS-1:0]      digit_bad;

  // The combined register moves one bit from the BCD half into the binary half.
  assign shifted   = {bcd_reg, bin_reg} >> 1;
  assign bcd_shift = shifted[2*SR_W-1:SR_W];
  assign bin_shift = shifted[SR_W-1:0];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adjust u_adjust (
        .digit    (bcd_shift[gi*DIGIT_W +: DIGIT_W]),
        .adjusted (bcd_adj[gi*DIGIT_W +: DIGIT_W])
      );

      assign digit_bad[gi] = digit_invalid(bcd[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    bcd_next    = bcd_reg;
    bin_next    = bin_reg;
    cnt_next    = cnt_reg;
    err_next    = err_reg;
    done_next   = 1'b0;
    binary_next = binary_reg;
    error_next  = error_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          bcd_next   = bcd;
          bin_next   = '0;
          cnt_next   = '0;
          err_next   = |digit_bad;
          state_next = CONV;
        end
      end

      CONV: begin
        bcd_next = bcd_adj;
        bin_next = bin_shift;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          state_next  = IDLE;
          done_next   = 1'b1;
          // Bad operands still walk the datapath; only the published result is masked.
          binary_next = err_reg ? '0 : bin_shift[BIN_WIDTH-1:0];
          error_next  = err_reg;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      bcd_reg    <= '0;
      bin_reg    <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      binary_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bcd_reg    <= bcd_next;
      bin_reg    <= bin_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
      binary_reg <= binary_next;
      error_reg  <= error_next;
    end
  end

  assign busy   = (state_reg == CONV);
  assign done   = done_reg;
  assign binary = binary_reg;
  assign error  = error_reg;

endmodule : bcd_binary_seq
